// File: rtl/trace_line_arbiter.sv
// Arbitrates whole '^'..'#' trace lines from two requesters onto one shared
// cpu_checker and returns the checker's verdict for each line to its owner.
module trace_line_arbiter #(
  parameter int unsigned MAX_LEN = 48,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  input  logic [15:0]      req0_freq,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  input  logic [15:0]      req1_freq,
  output logic             req1_ready,
  output logic [7:0]       chk_char,
  output logic [15:0]      chk_freq,
  input  logic [1:0]       chk_format,
  input  logic [3:0]       chk_error,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [1:0]       rsp_format,
  output logic [3:0]       rsp_error,
  output logic             rsp_abort,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [7:0]  CH_START = 8'h5E;
  localparam logic [7:0]  CH_END   = 8'h23;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RES0, S_RES1} state_e;

  state_e             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               grant_q, grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               abort_q, abort_d;
  logic [7:0]         chk_char_q, chk_char_d;
  logic [15:0]        chk_freq_q, chk_freq_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [1:0]         rsp_format_q, rsp_format_d;
  logic [3:0]         rsp_error_q, rsp_error_d;
  logic               rsp_abort_q, rsp_abort_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic elig0, elig1, any_elig, win_sel;
  logic sel_valid, len_full;
  logic [7:0] sel_char;

  assign elig0     = req0_valid && (req0_char == CH_START);
  assign elig1     = req1_valid && (req1_char == CH_START);
  assign any_elig  = elig0 || elig1;
  // On contention the requester that did not own the previous line wins.
  assign win_sel   = (elig0 && elig1) ? ~rr_last_q : elig1;
  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_char  = grant_q ? req1_char : req0_char;
  assign len_full  = (len_q == LEN_W'(MAX_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_last_q    <= 1'b1;
      grant_q      <= 1'b0;
      len_q        <= '0;
      abort_q      <= 1'b0;
      chk_char_q   <= 8'h00;
      chk_freq_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_format_q <= '0;
      rsp_error_q  <= '0;
      rsp_abort_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      grant_q      <= grant_d;
      len_q        <= len_d;
      abort_q      <= abort_d;
      chk_char_q   <= chk_char_d;
      chk_freq_q   <= chk_freq_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_format_q <= rsp_format_d;
      rsp_error_q  <= rsp_error_d;
      rsp_abort_q  <= rsp_abort_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_elig) state_d = S_STREAM;
      S_STREAM: if (len_full || !sel_valid || (sel_char == CH_END)) state_d = S_RES0;
      S_RES0:   state_d = S_RES1;
      S_RES1:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rr_last_d    = rr_last_q;
    grant_d      = grant_q;
    len_d        = len_q;
    abort_d      = abort_q;
    chk_char_d   = 8'h00;
    chk_freq_d   = chk_freq_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_format_d = rsp_format_q;
    rsp_error_d  = rsp_error_q;
    rsp_abort_d  = rsp_abort_q;
    err_count_d  = err_count_q;
    case (state_q)
      S_IDLE: begin
        // Stray characters are drained; a losing '^' is held for the next round.
        req0_ready = req0_valid && (!elig0 || (any_elig && !win_sel));
        req1_ready = req1_valid && (!elig1 || (any_elig && win_sel));
        if (any_elig) begin
          grant_d    = win_sel;
          chk_char_d = CH_START;
          chk_freq_d = win_sel ? req1_freq : req0_freq;
          len_d      = LEN_W'(1);
          abort_d    = 1'b0;
        end
      end
      S_STREAM: begin
        if (len_full || !sel_valid) begin
          abort_d = 1'b1;
        end else begin
          req0_ready = !grant_q;
          req1_ready = grant_q;
          chk_char_d = sel_char;
          len_d      = len_q + LEN_W'(1);
        end
      end
      S_RES1: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = grant_q;
        rsp_abort_d  = abort_q;
        rsp_format_d = abort_q ? 2'b00 : chk_format;
        rsp_error_d  = abort_q ? 4'h0 : chk_error;
        rr_last_d    = grant_q;
        if (((rsp_format_d == 2'b00) || (rsp_error_d != 4'h0)) && (err_count_q != '1))
          err_count_d = err_count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign chk_char   = chk_char_q;
  assign chk_freq   = chk_freq_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_format = rsp_format_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_abort  = rsp_abort_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/trace_line_arbiter.md
Name: trace_line_arbiter

Overview:
- Shares one cpu_checker instance between two trace-character requesters.
- Grants whole lines, from '^' through '#', in round-robin order, and streams the granted characters one per clock.
- Muxes the per-requester freq configuration into the checker.
- Captures the checker's format_type and error_code for each line and returns them to the owning requester as a one-cycle response.

Parameters:
- MAX_LEN, 48: maximum characters per line including '^' and '#'; exceeding it aborts the line.
- CNT_W, 16: width of the saturating error-line counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 presents a character.
- req0_char  input  8  requester 0 character.
- req0_freq  input  16  requester 0 freq setting for the checker.
- req0_ready  output  1  requester 0 character consumed this cycle.
- req1_valid, req1_char, req1_freq, req1_ready: same as requester 0, for requester 1.
- chk_char  output  8  character to checker.char.
- chk_freq  output  16  value to checker.freq.
- chk_format  input  2  checker.format_type.
- chk_error  input  4  checker.error_code.
- rsp_valid  output  1  one-cycle line result strobe.
- rsp_id  output  1  requester owning the result.
- rsp_format  output  2  captured format_type (0 = invalid line).
- rsp_error  output  4  captured error_code.
- rsp_abort  output  1  line was aborted (stall or length overrun).
- err_count  output  CNT_W  lines with rsp_error!=0 or rsp_format==0; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state=IDLE, rr_last=1 so requester 0 wins first.
  - chk_char=8'h00, chk_freq=0.
  - rsp_valid=0, rsp_id=0, rsp_format=0, rsp_error=0, rsp_abort=0.
  - err_count=0, len=0.
- Reset mid-line discards the line with no response. The checker shares the same reset.
- chk_char and chk_freq are registered. A character accepted at edge N appears on chk_char in cycle N+1 and is sampled by the checker at edge N+1.
- IDLE:
  - A requester is eligible when valid=1 and char=="^".
  - Any valid non-'^' character from a requester is consumed (ready=1) and discarded.
  - If both are eligible, grant the requester != rr_last. If one is eligible, grant it.
  - On grant: accept the '^' (ready=1), load chk_char='^', latch grant_id, latch chk_freq=req_freq[grant_id], set len=1, go to STREAM.
  - chk_char=8'h00 whenever nothing is forwarded.
- STREAM:
  - ready of the granted requester = its valid; the other requester's ready=0.
  - Each valid character goes to chk_char and len increments.
  - Accepted '#': go to RESULT.
  - Granted valid=0 for any cycle: abort. chk_char=8'h00, go to RESULT with abort=1.
  - Reaching MAX_LEN without '#': the next character is not accepted, chk_char=8'h00, abort=1, go to RESULT.
  - chk_freq is held constant for the whole line.
- RESULT (two cycles):
  - Cycle R0: checker is sampling the '#' or the 00. Wait.
  - Cycle R1: the checker's combinational outputs reflect the line end. At edge R1, register rsp_format, rsp_error, rsp_id=grant_id and rsp_abort; pulse rsp_valid in the following cycle.
  - Set rr_last=grant_id and return to IDLE.
  - rsp_format and rsp_error are forced to 0 when abort=1.
  - Latency from the '#' being accepted to rsp_valid is 3 cycles.
- Back-to-back lines: rsp_valid and the next grant may occur in the same cycle. The checker tolerates '^' straight after the line end.
- err_count increments on rsp_valid when rsp_abort=1, rsp_format==0 or rsp_error!=0. It holds at 2^CNT_W-1.
- No requester is starved: after a line completes, the other eligible requester always wins the next grant.

Test Plan:
- Req0 sends "^10@00003000: $5 <= 0000000a#", req1 idle, freq=2 → chk_char echoes the line 1 cycle late; rsp_valid 3 cycles after '#' with id=0, format=1, error=0, abort=0; err_count=0.
- Both present '^' together in IDLE after reset → req0 granted first; req1's ready stays 0 until req0's line completes, then req1 granted. Next contention goes to req0.
- Req1 sends "^3@00003001: *00004000 <= 00000001#" with freq=4 → rsp id=1, format=2, error=4'b0111; err_count=1.
- Req0 drops valid after "^12@0000" → chk_char=00 next cycle; rsp abort=1, format=0, error=0; err_count increments.
- Req0 sends 48 characters without '#' → the 49th is not accepted, abort=1; "xy" sent before '^' is consumed and never reaches chk_char.
- Assert reset mid-STREAM → all outputs return to reset values asynchronously; no rsp_valid; the next line is arbitrated normally.
